// File: rtl/limb_control.sv
// rtl/limb_control.sv - Limb 8-bit CPU fetch/decode/execute sequencer
module limb_control #(
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [3:0]  rf_src_a,
  output logic [3:0]  rf_src_b,
  input  logic [7:0]  rf_out_a,
  input  logic [7:0]  rf_out_b,
  output logic        rf_we,
  output logic [3:0]  rf_dst,
  output logic [7:0]  rf_wdata,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  pc,
  output logic        halted,
  output logic        fault
);

  localparam int SPW = $clog2(STACK_DEPTH) + 1;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_BRANCH = 3'd1;
  localparam logic [2:0] C_LOAD   = 3'd2;
  localparam logic [2:0] C_STORE  = 3'd3;
  localparam logic [2:0] C_CALL   = 3'd4;
  localparam logic [2:0] C_RET    = 3'd5;
  localparam logic [2:0] C_HALT   = 3'd6;

  logic [2:0]     state_q, state_d;
  logic [7:0]     pc_q, pc_d;
  logic [31:0]    ir_q, ir_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [7:0]     op_a_q, op_a_d;
  logic [7:0]     op_b_q, op_b_d;
  logic           fault_q, fault_d;
  logic [7:0]     stack_q [STACK_DEPTH];
  logic           push_en;

  logic [7:0]     opc, arg1, arg2, dst, pc_inc;
  logic [2:0]     cls, func;
  logic           is_mem, taken;
  logic [SPW-1:0] sp_dec;

  assign opc    = ir_q[31:24];
  assign arg1   = ir_q[23:16];
  assign arg2   = ir_q[15:8];
  assign dst    = ir_q[7:0];
  assign cls    = opc[5:3];
  assign func   = opc[2:0];
  assign is_mem = (cls == C_LOAD) || (cls == C_STORE);
  assign pc_inc = pc_q + 8'd1;
  assign sp_dec = sp_q - SPW'(1);

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign halted   = (state_q == S_HALT);
  assign fault    = fault_q;

  always_comb begin
    case (func)
      3'd0:    taken = (op_a_q == op_b_q);
      3'd1:    taken = (op_a_q != op_b_q);
      3'd2:    taken = (op_a_q <  op_b_q);
      3'd3:    taken = (op_a_q <= op_b_q);
      3'd4:    taken = (op_a_q >  op_b_q);
      3'd5:    taken = (op_a_q >= op_b_q);
      3'd6:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    sp_d      = sp_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    fault_d   = fault_q;
    push_en   = 1'b0;
    rf_src_a  = 4'd0;
    rf_src_b  = 4'd0;
    rf_we     = 1'b0;
    rf_dst    = 4'd0;
    rf_wdata  = 8'd0;
    alu_op    = 3'd0;
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = rom_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Memory ops always address through r15, so its immediate bit is ignored.
        rf_src_a = arg1[3:0];
        rf_src_b = is_mem ? 4'd15 : arg2[3:0];
        op_a_d   = opc[7] ? arg1 : rf_out_a;
        op_b_d   = (opc[6] && !is_mem) ? arg2 : rf_out_b;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (cls)
          C_ALU: begin
            alu_op   = func;
            alu_a    = op_a_q;
            alu_b    = op_b_q;
            rf_we    = (dst[3:0] != 4'd0);
            rf_dst   = dst[3:0];
            rf_wdata = alu_result;
          end
          C_BRANCH: pc_d = taken ? dst : pc_inc;
          C_LOAD, C_STORE: begin
            pc_d    = pc_q;
            state_d = S_MEM;
          end
          C_CALL: begin
            if (sp_q == SPW'(STACK_DEPTH)) begin
              fault_d = 1'b1;
              pc_d    = pc_q;
              state_d = S_HALT;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SPW'(1);
              pc_d    = dst;
            end
          end
          C_RET: begin
            if (sp_q == '0) begin
              fault_d = 1'b1;
              pc_d    = pc_q;
              state_d = S_HALT;
            end else begin
              sp_d = sp_dec;
              pc_d = stack_q[sp_dec[SPW-2:0]];
            end
          end
          C_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = op_b_q;
        mem_we    = (cls == C_STORE);
        mem_wdata = op_a_q;
        if (mem_ack) begin
          if (cls == C_LOAD) begin
            rf_we    = (dst[3:0] != 4'd0);
            rf_dst   = dst[3:0];
            rf_wdata = mem_rdata;
          end
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= 8'd0;
      ir_q    <= 32'd0;
      sp_q    <= '0;
      op_a_q  <= 8'd0;
      op_b_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      fault_q <= fault_d;
    end
  end

  // Return-address storage needs no reset: sp gates every read.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q[SPW-2:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_limb_control.sv
// tb/tb_limb_control.sv - directed self-checking bench for limb_control
module tb_limb_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [3:0]  rf_src_a, rf_src_b, rf_dst;
  logic [7:0]  rf_out_a, rf_out_b, rf_wdata;
  logic        rf_we;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  pc;
  logic        halted, fault;

  logic [31:0] rom [256];
  logic [7:0]  rf  [16];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign rom_data   = rom[rom_addr];
  assign rf_out_a   = rf[rf_src_a];
  assign rf_out_b   = rf[rf_src_b];
  assign alu_result = (alu_op == 3'd0) ? alu_a + alu_b : alu_a - alu_b;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      rf[15] <= 8'h10;
    end else if (rf_we && rf_dst != 4'd0) begin
      rf[rf_dst] <= rf_wdata;
    end
  end

  limb_control #(.STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rf_src_a(rf_src_a), .rf_src_b(rf_src_b),
    .rf_out_a(rf_out_a), .rf_out_b(rf_out_b),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .halted(halted), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds reset and fills ROM with HALT (0x30) so runaway fetches stop.
  task automatic start_reset();
    @(negedge clk);
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 32'h3000_0000;
  endtask

  task automatic release_run();
    @(negedge clk);
    reset = 1'b1; run = 1'b1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;

    // Reset state with run low.
    start_reset();
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    @(negedge clk) reset = 1'b1;
    tick(4);
    check("run0_rom_addr", rom_addr, 8'h00);
    check("run0_rf_we", rf_we, 1'b0);
    check("run0_mem_req", mem_req, 1'b0);

    // ALU imm/imm add: 5 + 3 -> r2.
    start_reset();
    rom[0] = 32'hC0_05_03_02;
    release_run();
    tick(2);
    check("alu_rf_we", rf_we, 1'b1);
    check("alu_rf_dst", rf_dst, 4'd2);
    check("alu_a", alu_a, 8'd5);
    check("alu_b", alu_b, 8'd3);
    check("alu_wdata", rf_wdata, 8'd8);
    tick(1);
    check("alu_pc", pc, 8'h01);
    check("alu_we_pulse", rf_we, 1'b0);
    check("alu_r2", rf[2], 8'd8);

    // Branch EQ taken / not taken.
    start_reset();
    rom[0] = 32'hC8_07_07_40;
    release_run();
    tick(3);
    check("br_eq_taken", pc, 8'h40);
    start_reset();
    rom[0] = 32'hC8_07_08_40;
    release_run();
    tick(3);
    check("br_eq_not", pc, 8'h01);

    // Branch-always to 0xFF, then untaken branch there wraps to 0.
    start_reset();
    rom[0]   = 32'hCE_00_00_FF;
    rom[255] = 32'hC8_07_08_40;
    release_run();
    tick(3);
    check("br_always", pc, 8'hFF);
    tick(3);
    check("br_wrap", pc, 8'h00);

    // Load from r15 (0x10) into r3, ack after 4 MEM cycles.
    start_reset();
    rom[0] = 32'h10_00_00_03;
    release_run();
    tick(1);
    check("ld_src_b", rf_src_b, 4'd15);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      check("ld_req_hold", mem_req, 1'b1);
      check("ld_addr", mem_addr, 8'h10);
      check("ld_we", mem_we, 1'b0);
      tick(1);
    end
    mem_ack = 1'b1; mem_rdata = 8'hAB;
    #1;
    check("ld_req_ack", mem_req, 1'b1);
    check("ld_rf_we", rf_we, 1'b1);
    check("ld_rf_dst", rf_dst, 4'd3);
    check("ld_wdata", rf_wdata, 8'hAB);
    tick(1);
    mem_ack = 1'b0;
    #1;
    check("ld_pc", pc, 8'h01);
    check("ld_r3", rf[3], 8'hAB);
    check("ld_req_drop", mem_req, 1'b0);

    // Load into r0 never strobes rf_we.
    start_reset();
    rom[0] = 32'h10_00_00_00;
    release_run();
    tick(3);
    mem_ack = 1'b1; mem_rdata = 8'h55;
    #1;
    check("ld0_rf_we", rf_we, 1'b0);
    tick(1);
    mem_ack = 1'b0;

    // Store immediate 0x5A to [r15].
    start_reset();
    rom[0] = 32'h98_5A_00_00;
    release_run();
    tick(3);
    check("st_we", mem_we, 1'b1);
    check("st_wdata", mem_wdata, 8'h5A);
    check("st_addr", mem_addr, 8'h10);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    #1;
    check("st_pc", pc, 8'h01);

    // CALL at 5 to 0x20, RET to 6, HALT there; run toggling has no effect.
    start_reset();
    for (int i = 0; i < 5; i++) rom[i] = 32'h3800_0000;
    rom[5]  = 32'h20_00_00_20;
    rom[32] = 32'h28_00_00_00;
    rom[6]  = 32'h30_00_00_00;
    release_run();
    tick(15);
    check("call_pre_pc", pc, 8'h05);
    tick(3);
    check("call_pc", pc, 8'h20);
    tick(3);
    check("ret_pc", pc, 8'h06);
    tick(3);
    check("halt_halted", halted, 1'b1);
    check("halt_fault", fault, 1'b0);
    run = 1'b0; tick(2); run = 1'b1; tick(3);
    check("halt_pc_frozen", pc, 8'h06);

    // Nine nested CALLs overflow an 8-deep stack at pc 8.
    start_reset();
    for (int i = 0; i < 9; i++) rom[i] = {8'h20, 16'h0000, 8'(i + 1)};
    release_run();
    tick(27);
    check("ovf_fault", fault, 1'b1);
    check("ovf_halted", halted, 1'b1);
    check("ovf_pc", pc, 8'h08);

    // RET with empty stack.
    start_reset();
    rom[0] = 32'h28_00_00_00;
    release_run();
    tick(3);
    check("unf_fault", fault, 1'b1);
    check("unf_halted", halted, 1'b1);
    check("unf_pc", pc, 8'h00);

    // Asynchronous reset while a load at pc 1 waits in MEM.
    start_reset();
    rom[0] = 32'h3800_0000;
    rom[1] = 32'h10_00_00_03;
    release_run();
    tick(6);
    check("rmem_req_before", mem_req, 1'b1);
    check("rmem_pc_before", pc, 8'h01);
    #2 reset = 1'b0;
    #1;
    check("rmem_req", mem_req, 1'b0);
    check("rmem_pc", pc, 8'h00);
    check("rmem_addr", mem_addr, 8'h00);
    check("rmem_rf_we", rf_we, 1'b0);
    run = 1'b0;
    @(negedge clk) mem_ack = 1'b1;
    reset = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    #1;
    check("rmem_ack_ignored", rf_we, 1'b0);
    check("rmem_pc_after", pc, 8'h00);
    check("rmem_r3", rf[3], 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/limb_control.md
Name: limb_control

Overview:
- Multi-cycle fetch/decode/execute sequencer for the Limb 8-bit CPU.
- Owns pc, ir and the hardware call stack (sp). Drives program ROM address, register file ports, ALU opcode/operands and the RAM load/store handshake.
- Instruction is 32 bits: [31:24] opcode, [23:16] arg1, [15:8] arg2, [7:0] dst/target.

Parameters:
STACK_DEPTH, 8, number of return-address entries in the internal call stack (power of 2, 2..16)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  1 = allow instruction fetch; sampled only in FETCH
rom_addr  out  8  program ROM address (= pc)
rom_data  in  32  ROM word, combinational from rom_addr
rf_src_a  out  4  register read index A
rf_src_b  out  4  register read index B
rf_out_a  in  8  register value A (combinational)
rf_out_b  in  8  register value B (combinational)
rf_we  out  1  register write strobe
rf_dst  out  4  register write index
rf_wdata  out  8  register write data
alu_op  out  3  ALU function select
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_result  in  8  ALU result (combinational)
mem_req  out  1  RAM request, held until mem_ack
mem_we  out  1  1 = store, 0 = load; valid with mem_req
mem_addr  out  8  RAM address (value of r15)
mem_wdata  out  8  store data
mem_rdata  in  8  load data, valid in mem_ack cycle
mem_ack  in  1  RAM completion, one-cycle pulse
pc  out  8  current program counter
halted  out  1  core stopped (HALT or fault)
fault  out  1  call-stack overflow/underflow occurred

Behaviour:
- Reset (reset=0, async): state=FETCH, pc=0, ir=0, sp=0, all outputs 0, halted=0, fault=0.
- Opcode decode:
  - bit7: arg1 is immediate. bit6: arg2 is immediate.
  - [5:3] class: 0 ALU, 1 BRANCH, 2 LOAD, 3 STORE, 4 CALL, 5 RET, 6 HALT, 7 NOP.
  - [2:0] func.
- Register indices: arg1[3:0] and arg2[3:0]. dst register index is dst[3:0].
- FETCH:
  - rom_addr=pc.
  - If run=1: ir<=rom_data, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - rf_src_a=arg1[3:0].
  - rf_src_b=arg2[3:0], except LOAD/STORE, which use rf_src_b=15.
  - Latch op_a = imm1 ? arg1 : rf_out_a.
  - Latch op_b = imm2 ? arg2 : rf_out_b. For LOAD/STORE, op_b=rf_out_b (r15), regardless of imm2.
  - Go to EXEC.
- EXEC by class:
  - ALU: alu_op=func, alu_a=op_a, alu_b=op_b, rf_we=1 (0 if dst[3:0]==0), rf_dst=dst[3:0], rf_wdata=alu_result; pc<=pc+1; go to FETCH. Latency: 3 cycles.
  - BRANCH: unsigned compare. func 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 always, 7 never. Taken: pc<=dst. Not taken: pc<=pc+1. Go to FETCH.
  - LOAD/STORE: go to MEM.
  - CALL: if sp==STACK_DEPTH, set fault=1 and go to HALT with pc unchanged. Otherwise stack[sp]<=pc+1, sp<=sp+1, pc<=dst, go to FETCH.
  - RET: if sp==0, set fault=1 and go to HALT. Otherwise sp<=sp-1, pc<=stack[sp-1], go to FETCH.
  - HALT: go to HALT with pc unchanged.
  - NOP: pc<=pc+1, go to FETCH.
- MEM:
  - mem_req=1, mem_addr=op_b, mem_we=(class==STORE), mem_wdata=op_a.
  - All held stable until mem_ack. Waits indefinitely.
  - On mem_ack:
    - LOAD: rf_we=1 (masked for dst[3:0]==0), rf_dst=dst[3:0], rf_wdata=mem_rdata in that same cycle.
    - Then pc<=pc+1, go to FETCH.
  - mem_ack outside MEM is ignored.
- HALT: halted=1. Terminal until reset; run has no effect.
- Strobes: rf_we and mem_req are never asserted outside EXEC/MEM as specified. rf_we is a single-cycle pulse.
- Wrap-around: pc+1 wraps 255->0. A branch/call target of 0 is legal.
- run deasserted mid-instruction: the current instruction completes; the core stalls at the next FETCH.
- Reset mid-MEM: mem_req drops immediately (async); any pending ack is ignored.

Test Plan:
- ALU: ROM[0] = opcode 0xC0 (ALU imm/imm, func 0), arg1=5, arg2=3, dst=2 -> after 3 cycles rf_we pulse with rf_dst=2 and alu_a=5, alu_b=3; pc=1.
- Branch: ROM[0] = class 1, func 0 (EQ), both imm 7/7, target 0x40 -> pc=0x40. Repeat with 7/8 -> pc=1. Branch at pc=255 not taken -> pc=0.
- Load: r15=0x10, mem_ack delayed 4 cycles, mem_rdata=0xAB, dst=3 -> mem_req held for 4 cycles with mem_addr=0x10 and mem_we=0; rf_wdata=0xAB written to r3 in the ack cycle. With dst=0 -> rf_we stays 0.
- Call stack: CALL 0x20 at pc=5, then RET -> pc=0x20, then 6. STACK_DEPTH+1 nested CALLs -> fault=1, halted=1, pc holds at the last CALL. RET with sp=0 -> fault=1.
- Control: HALT instruction -> halted=1, fault=0, pc frozen while run toggles. run=0 at reset -> rom_addr=0 and no strobes. Assert reset during MEM -> all outputs 0 and pc=0 asynchronously.
